// File: rtl/vx_cache_sets_reconfig_ctrl.sv
// Runtime set-count reconfiguration controller: gates core lanes, drains
// outstanding reads, flushes the cache, then commits the new set count.
module vx_cache_sets_reconfig_ctrl #(
    parameter int NUM_REQS        = 4,
    parameter int SETS_WIDTH      = 12,
    parameter int DEFAULT_SETS    = 64,
    parameter int MAX_SETS        = 1024,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    input  logic [SETS_WIDTH-1:0] cfg_sets,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  busy,
    input  logic [NUM_REQS-1:0]   req_valid_in,
    input  logic [NUM_REQS-1:0]   req_rw_in,
    output logic [NUM_REQS-1:0]   req_ready_out,
    output logic [NUM_REQS-1:0]   req_valid_out,
    input  logic [NUM_REQS-1:0]   req_ready_in,
    input  logic [NUM_REQS-1:0]   rsp_fire,
    output logic                  flush_req,
    input  logic                  flush_ack,
    output logic [SETS_WIDTH-1:0] unified_cache_sets
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic signed [CNT_W+1:0] CNT_MAX_S = (CNT_W+2)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, APPLY} state_e;

    state_e                 state_q;
    logic [SETS_WIDTH-1:0]  sets_q;
    logic [SETS_WIDTH-1:0]  pending_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   flush_req_q;
    logic                   cfg_done_q;
    logic                   cfg_err_q;
    logic                   busy_q;
    logic                   lanes_open;
    logic                   cfg_fire;
    logic [CNT_W:0]         inc_cnt;
    logic [CNT_W:0]         dec_cnt;
    logic signed [CNT_W+1:0] net_cnt;

    function automatic logic is_legal(input logic [SETS_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0)
            && ({1'b0, v} <= (SETS_WIDTH+1)'(MAX_SETS));
    endfunction

    function automatic logic [CNT_W:0] popcnt(input logic [NUM_REQS-1:0] v);
        logic [CNT_W:0] s;
        s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            s = s + {{CNT_W{1'b0}}, v[i]};
        end
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+1:0] v);
        if (v[CNT_W+1]) begin
            return '0;
        end else if (v > CNT_MAX_S) begin
            return CNT_W'(MAX_OUTSTANDING);
        end
        return v[CNT_W-1:0];
    endfunction

    assign lanes_open    = (state_q == IDLE);
    assign req_valid_out = lanes_open ? req_valid_in : '0;
    assign req_ready_out = lanes_open ? req_ready_in : '0;
    assign cfg_ready     = lanes_open && reset_n;
    assign cfg_fire      = cfg_valid && cfg_ready;

    assign flush_req          = flush_req_q;
    assign cfg_done           = cfg_done_q;
    assign cfg_err            = cfg_err_q;
    assign busy               = busy_q;
    assign unified_cache_sets = sets_q;

    // Writes are left to the flush; only read acceptances are tracked.
    always_comb begin
        inc_cnt = popcnt(req_valid_out & req_ready_in & ~req_rw_in);
        dec_cnt = popcnt(rsp_fire);
        net_cnt = $signed({2'b00, cnt_q}) + $signed({1'b0, inc_cnt})
                - $signed({1'b0, dec_cnt});
        cnt_d   = sat_cnt(net_cnt);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sets_q      <= SETS_WIDTH'(DEFAULT_SETS);
            cnt_q       <= '0;
            flush_req_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            assert (!net_cnt[CNT_W+1] && (net_cnt <= CNT_MAX_S));
            cnt_q      <= cnt_d;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_fire) begin
                        if (!is_legal(cfg_sets)) begin
                            cfg_err_q <= 1'b1;
                        end else if (cfg_sets == sets_q) begin
                            cfg_done_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q     <= FLUSH;
                        flush_req_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        state_q     <= APPLY;
                        flush_req_q <= 1'b0;
                    end
                end
                APPLY: begin
                    sets_q     <= pending_q;
                    cfg_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data-only register: its content is meaningless outside DRAIN..APPLY.
    always_ff @(posedge clk) begin
        if (cfg_fire) begin
            pending_q <= cfg_sets;
        end
    end

endmodule
